// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   EX stage of a 5-stage MIPS32 pipeline. It resolves rs/rt forwarding from
//   EX/MEM and MEM/WB, evaluates the ALU, runs a 32-cycle iterative unsigned
//   shift-add multiplier that feeds the HI/LO registers, and registers the
//   result into the EX/MEM pipeline register.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   ID_EX_CU_signals[5:0]  {RegDst, ALUSrc, MemWrite, MemRead, RegWrite, MemtoReg}
//   ID_EX_ALU_ctrl[3:0]    ALU operation code
//   ID_EX_rs_data/rt_data  register-file read data
//   ID_EX_imm_ext          extended immediate
//   ID_EX_rs/rt/rd_addr    register addresses, ID_EX_shamt shift amount
//   MEM_WB_RegWrite/wr_addr/wr_data  writeback forwarding source
//   EX_MEM_CU_signals[3:0] {MemWrite, MemRead, RegWrite, MemtoReg}, registered
//   EX_MEM_wr_addr         destination register, registered
//   EX_MEM_ALU_result      ALU result / memory address, registered
//   EX_MEM_DMEM_wr_data    forwarded rt for stores, registered
//   EX_stall               combinational stall toward PC, IF/ID and ID/EX
// ---------------------------------------------------------------------------
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ID_EX_CU_signals,
  input  logic [3:0]  ID_EX_ALU_ctrl,
  input  logic [31:0] ID_EX_rs_data,
  input  logic [31:0] ID_EX_rt_data,
  input  logic [31:0] ID_EX_imm_ext,
  input  logic [4:0]  ID_EX_rs_addr,
  input  logic [4:0]  ID_EX_rt_addr,
  input  logic [4:0]  ID_EX_rd_addr,
  input  logic [4:0]  ID_EX_shamt,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_wr_addr,
  input  logic [31:0] MEM_WB_wr_data,
  output logic [3:0]  EX_MEM_CU_signals,
  output logic [4:0]  EX_MEM_wr_addr,
  output logic [31:0] EX_MEM_ALU_result,
  output logic [31:0] EX_MEM_DMEM_wr_data,
  output logic        EX_stall
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_LUI   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mul_state_e;

  // EX/MEM pipeline register
  logic [3:0]  ex_mem_cu_q,   ex_mem_cu_d;
  logic [4:0]  ex_mem_addr_q, ex_mem_addr_d;
  logic [31:0] ex_mem_res_q,  ex_mem_res_d;
  logic [31:0] ex_mem_data_q, ex_mem_data_d;

  // Multiplier state
  mul_state_e  state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] rs_fwd, rt_fwd, op_a, op_b, alu_res;
  logic [63:0] step_sum;
  logic        is_mul_op;

  // Forwarding mux: EX/MEM outranks MEM/WB; register 0 is never forwarded.
  // Only the ALU result is available from EX/MEM, load-use is handled by decode.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src_addr,
    input logic [31:0] id_data,
    input logic        exm_we,
    input logic [4:0]  exm_addr,
    input logic [31:0] exm_data,
    input logic        wb_we,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data
  );
    if (exm_we && (exm_addr != 5'd0) && (exm_addr == src_addr))
      return exm_data;
    else if (wb_we && (wb_addr != 5'd0) && (wb_addr == src_addr))
      return wb_data;
    else
      return id_data;
  endfunction

  function automatic logic [31:0] alu_eval(
    input logic [3:0]  ctrl,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] imm,
    input logic [4:0]  sh,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    a_s = a;
    b_s = b;
    case (ctrl)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_ADD:   return a + b;
      OP_XOR:   return a ^ b;
      OP_NOR:   return ~(a | b);
      OP_SUB:   return a - b;
      OP_SLT:   return {31'd0, (a_s < b_s)};
      OP_SLTU:  return {31'd0, (a < b)};
      OP_SLL:   return b << sh;
      OP_SRL:   return b >> sh;
      OP_SRA:   return b_s >>> sh;
      OP_LUI:   return {imm[15:0], 16'd0};
      OP_MFHI:  return hi;
      OP_MFLO:  return lo;
      default:  return 32'd0;  // MULTU and the reserved code
    endcase
  endfunction

  assign rs_fwd = fwd_sel(ID_EX_rs_addr, ID_EX_rs_data, ex_mem_cu_q[1], ex_mem_addr_q,
                          ex_mem_res_q, MEM_WB_RegWrite, MEM_WB_wr_addr, MEM_WB_wr_data);
  assign rt_fwd = fwd_sel(ID_EX_rt_addr, ID_EX_rt_data, ex_mem_cu_q[1], ex_mem_addr_q,
                          ex_mem_res_q, MEM_WB_RegWrite, MEM_WB_wr_addr, MEM_WB_wr_data);

  assign op_a    = rs_fwd;
  assign op_b    = ID_EX_CU_signals[4] ? ID_EX_imm_ext : rt_fwd;
  assign alu_res = alu_eval(ID_EX_ALU_ctrl, op_a, op_b, ID_EX_imm_ext, ID_EX_shamt, hi_q, lo_q);

  // MULTU/MFHI/MFLO occupy the top three codes.
  assign is_mul_op = (ID_EX_ALU_ctrl == OP_MULTU) || (ID_EX_ALU_ctrl == OP_MFHI) ||
                     (ID_EX_ALU_ctrl == OP_MFLO);
  assign EX_stall  = (state_q == S_BUSY) && is_mul_op;

  // Partial product for the current multiplier bit; the final step's sum is
  // the complete product and goes straight into HI/LO.
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (state_q == S_IDLE) begin
      if ((ID_EX_ALU_ctrl == OP_MULTU) && !EX_stall) begin
        state_d  = S_BUSY;
        mcand_d  = {32'd0, op_a};
        mplier_d = op_b;
        acc_d    = 64'd0;
        cnt_d    = 5'd0;
      end
    end else begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        {hi_d, lo_d} = step_sum;
        state_d      = S_IDLE;
      end
    end
  end

  always_comb begin
    ex_mem_cu_d   = 4'd0;
    ex_mem_addr_d = 5'd0;
    ex_mem_res_d  = 32'd0;
    ex_mem_data_d = 32'd0;
    // A stalled instruction stays in ID/EX; EX/MEM receives a bubble.
    if (!EX_stall) begin
      ex_mem_cu_d   = ID_EX_CU_signals[3:0];
      ex_mem_addr_d = ID_EX_CU_signals[5] ? ID_EX_rd_addr : ID_EX_rt_addr;
      ex_mem_res_d  = alu_res;
      ex_mem_data_d = rt_fwd;
    end
  end

  // EX -> MEM boundary, multiplier and HI/LO state
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_cu_q   <= 4'd0;
      ex_mem_addr_q <= 5'd0;
      ex_mem_res_q  <= 32'd0;
      ex_mem_data_q <= 32'd0;
      state_q       <= S_IDLE;
      mcand_q       <= 64'd0;
      mplier_q      <= 32'd0;
      acc_q         <= 64'd0;
      cnt_q         <= 5'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
    end else begin
      ex_mem_cu_q   <= ex_mem_cu_d;
      ex_mem_addr_q <= ex_mem_addr_d;
      ex_mem_res_q  <= ex_mem_res_d;
      ex_mem_data_q <= ex_mem_data_d;
      state_q       <= state_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
  end

  assign EX_MEM_CU_signals   = ex_mem_cu_q;
  assign EX_MEM_wr_addr      = ex_mem_addr_q;
  assign EX_MEM_ALU_result   = ex_mem_res_q;
  assign EX_MEM_DMEM_wr_data = ex_mem_data_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cu;
  logic [3:0]  op;
  logic [31:0] rs_d, rt_d, imm;
  logic [4:0]  rsa, rta, rda, sh;
  logic        wb_we;
  logic [4:0]  wb_a;
  logic [31:0] wb_d;
  logic [3:0]  o_cu;
  logic [4:0]  o_addr;
  logic [31:0] o_res, o_data;
  logic        o_stall;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .ID_EX_CU_signals(cu), .ID_EX_ALU_ctrl(op),
    .ID_EX_rs_data(rs_d), .ID_EX_rt_data(rt_d), .ID_EX_imm_ext(imm),
    .ID_EX_rs_addr(rsa), .ID_EX_rt_addr(rta), .ID_EX_rd_addr(rda), .ID_EX_shamt(sh),
    .MEM_WB_RegWrite(wb_we), .MEM_WB_wr_addr(wb_a), .MEM_WB_wr_data(wb_d),
    .EX_MEM_CU_signals(o_cu), .EX_MEM_wr_addr(o_addr),
    .EX_MEM_ALU_result(o_res), .EX_MEM_DMEM_wr_data(o_data),
    .EX_stall(o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [3:0]  cu;
    logic [4:0]  addr;
    logic [31:0] res;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic last_stall = 1'b0;

  // Reference state: architectural view of the stage
  logic [3:0]  m_cu = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_res = '0, m_data = '0, m_hi = '0, m_lo = '0;
  logic [63:0] m_prod = '0;
  int          mb_left = 0;  // cycles of multiply still outstanding

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
    if (m_cu[1] && m_addr != 0 && m_addr == a) return m_res;
    if (wb_we && wb_a != 0 && wb_a == a) return wb_d;
    return d;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sx;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd6:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return 32'(64'(b) * (64'd1 << sh));
      4'd10: return 32'(64'(b) / (64'd1 << sh));
      4'd11: begin sx = {{32{b[31]}}, b}; sx = sx >> sh; return sx[31:0]; end
      4'd12: return imm * 32'h1_0000;
      4'd14: return m_hi;
      4'd15: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(output exp_t e);
    logic [31:0] rsv, rtv, a, b;
    e.stall = (mb_left > 0) && (op >= 4'd13);
    e.cu = 0; e.addr = 0; e.res = 0; e.data = 0;
    if (rst) begin
      mb_left = 0; m_hi = 0; m_lo = 0;
    end else begin
      rsv = fwd(rsa, rs_d);
      rtv = fwd(rta, rt_d);
      a = rsv;
      b = cu[4] ? imm : rtv;
      if (!e.stall) begin
        e.cu = cu[3:0];
        e.addr = cu[5] ? rda : rta;
        e.res = ref_alu(a, b);
        e.data = rtv;
      end
      if (mb_left > 0) begin
        mb_left--;
        if (mb_left == 0) {m_hi, m_lo} = m_prod;
      end else if (op == 4'd13) begin
        mb_left = 32;
        m_prod = 64'(a) * 64'(b);
      end
    end
    m_cu = e.cu; m_addr = e.addr; m_res = e.res; m_data = e.data;
  endtask

  task automatic issue(input logic r, input logic [5:0] c, input logic [3:0] o,
                       input logic [31:0] a_d, input logic [31:0] b_d, input logic [31:0] im,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                       input logic [4:0] s, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    exp_t e;
    @(posedge clk); #1;
    rst = r; cu = c; op = o; rs_d = a_d; rt_d = b_d; imm = im;
    rsa = ra; rta = rb; rda = rd; sh = s; wb_we = we; wb_a = wa; wb_d = wd;
    model_step(e);
    q.push_back(e);
    last_stall = e.stall;
  endtask

  // Simple register-writing ALU op with no forwarding sources involved
  task automatic alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im, input logic src, input logic [4:0] s);
    issue(1'b0, {1'b1, src, 2'b00, 1'b1, 1'b0}, o, a, b, im, 5'd0, 5'd0, 5'd0, s, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic multu(input logic [31:0] a, input logic [31:0] b);
    issue(1'b0, 6'd0, 4'd13, a, b, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Hold an HI/LO read in ID/EX until the stage accepts it
  task automatic mul_read(input logic [3:0] o);
    int n = 0;
    do begin
      issue(1'b0, 6'b100010, o, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
      n++;
    end while (last_stall && n < 40);
    if (last_stall) begin
      failures++;
      $display("FAIL mul_read_timeout: still stalled after %0d cycles, need release", n);
    end
  endtask

  // Monitor: every cycle the DUT presents a stall flag and, after the edge,
  // new EX/MEM contents; compare both against the queued expectation.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("EX_stall", {31'd0, o_stall}, {31'd0, it.stall});
        @(posedge clk); #2;
        chk("EX_MEM_CU", {28'd0, o_cu}, {28'd0, it.cu});
        chk("EX_MEM_wr_addr", {27'd0, o_addr}, {27'd0, it.addr});
        chk("EX_MEM_ALU_result", o_res, it.res);
        chk("EX_MEM_DMEM_wr_data", o_data, it.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  h_cu;
    logic [3:0]  h_op;
    logic [31:0] h_a, h_b, h_im;
    logic [4:0]  h_ra, h_rb, h_rd, h_s;
    rst = 1'b1; cu = 6'($urandom); op = 4'($urandom); rs_d = $urandom; rt_d = $urandom;
    imm = $urandom; rsa = 5'($urandom); rta = 5'($urandom); rda = 5'($urandom);
    sh = 5'($urandom); wb_we = 1'($urandom); wb_a = 5'($urandom); wb_d = $urandom;
    // second reset cycle with random inputs; the first edge is not scored
    issue(1'b1, 6'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
          5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), $urandom);

    // ALU sweep
    alu(4'd2,  32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd7,  32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd8,  32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd6,  32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd0,  32'hFFFF_FFF0, 32'h3C, 32'd0, 1'b0, 5'd0);
    alu(4'd1,  32'h0F0F_0000, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd3,  32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd4,  32'hFFFF_FFF0, 32'h20, 32'd0, 1'b0, 5'd0);
    alu(4'd11, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd4);
    alu(4'd10, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd4);
    alu(4'd9,  32'd0, 32'h8000_0001, 32'd0, 1'b0, 5'd4);
    alu(4'd12, 32'd0, 32'd0, 32'h1234, 1'b1, 5'd0);
    alu(4'd2,  32'h10, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    alu(4'd5,  32'h1234, 32'h5678, 32'd0, 1'b0, 5'd0);

    // Forwarding: EX/MEM beats MEM/WB; then MEM/WB alone; then register 0
    issue(1'b0, 6'b100010, 4'd2, 32'hAAAA, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
    issue(1'b0, 6'b100010, 4'd1, 32'h1234, 32'd0, 32'd0, 5'd5, 5'd0, 5'd1, 5'd0, 1'b1, 5'd5, 32'hBBBB);
    issue(1'b0, 6'b101000, 4'd2, 32'd0, 32'h77, 32'd0, 5'd5, 5'd5, 5'd1, 5'd0, 1'b1, 5'd5, 32'hBBBB);
    issue(1'b0, 6'b100010, 4'd2, 32'hAAAA, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    issue(1'b0, 6'b100010, 4'd1, 32'h1111, 32'h2222, 32'd0, 5'd0, 5'd0, 5'd2, 5'd0, 1'b1, 5'd0, 32'hBBBB);

    // Multiply then HI/LO reads held through the stall
    multu(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_read(4'd14);
    mul_read(4'd15);

    // Independent instructions flow during a multiply
    multu(32'd3, 32'd5);
    alu(4'd2, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0);
    alu(4'd2, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0);
    alu(4'd2, 32'd5, 32'd6, 32'd0, 1'b0, 5'd0);
    mul_read(4'd15);
    mul_read(4'd14);

    // Reset lands at multiplier count 10
    multu(32'd7, 32'd9);
    for (int i = 0; i < 10; i++) alu(4'd2, i, 32'd1, 32'd0, 1'b0, 5'd0);
    issue(1'b1, 6'd0, 4'd13, 32'd7, 32'd9, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    mul_read(4'd15);

    // Randomized traffic; a stalled instruction is held, MEM/WB keeps moving
    h_cu = 0; h_op = 0; h_a = 0; h_b = 0; h_im = 0; h_ra = 0; h_rb = 0; h_rd = 0; h_s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        h_op = ($urandom % 12 == 0) ? 4'(13 + $urandom % 3) : 4'($urandom % 13);
        h_cu = 6'($urandom);
        if (h_op == 4'd13) h_cu[1] = 1'b0;
        h_a  = ($urandom % 2) ? $urandom : 32'($urandom % 16);
        h_b  = ($urandom % 2) ? $urandom : 32'($urandom % 16);
        h_im = $urandom;
        h_ra = 5'($urandom % 8); h_rb = 5'($urandom % 8); h_rd = 5'($urandom % 8);
        h_s  = 5'($urandom);
      end
      issue(($urandom % 400 == 0), h_cu, h_op, h_a, h_b, h_im, h_ra, h_rb, h_rd, h_s,
            1'($urandom), 5'($urandom % 8), $urandom);
    end

    issue(1'b0, 6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, need 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage MIPS32 pipeline, between the ID/EX pipeline register and the memory stage. It resolves operand forwarding, runs the ALU and an iterative 32-cycle unsigned multiplier with HI/LO registers, and registers results into the EX/MEM pipeline register that drives the memory stage. It raises a stall toward decode when an instruction needs the multiplier while a multiply is still in progress.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- ID_EX_CU_signals  in  6  [5] RegDst, [4] ALUSrc, [3] MemWrite, [2] MemRead, [1] RegWrite, [0] MemtoReg.
- ID_EX_ALU_ctrl  in  4  ALU operation code, listed under Operation.
- ID_EX_rs_data / ID_EX_rt_data  in  32 each  register-file read data.
- ID_EX_imm_ext  in  32  sign- or zero-extended immediate.
- ID_EX_rs_addr / ID_EX_rt_addr / ID_EX_rd_addr / ID_EX_shamt  in  5 each.
- MEM_WB_RegWrite  in  1  writeback stage will write the register file.
- MEM_WB_wr_addr  in  5  writeback destination.
- MEM_WB_wr_data  in  32  writeback data, after the MemtoReg mux.
- EX_MEM_CU_signals  out  4  {MemWrite, MemRead, RegWrite, MemtoReg}, registered.
- EX_MEM_wr_addr  out  5  destination register, registered.
- EX_MEM_ALU_result  out  32  ALU result or memory address, registered.
- EX_MEM_DMEM_wr_data  out  32  forwarded rt value for stores, registered.
- EX_stall  out  1  combinational; holds PC, IF/ID and ID/EX upstream.

## Operation
- Forwarding for rs, applied to rt the same way:
  - Source 1 (highest priority): EX_MEM_ALU_result when EX_MEM RegWrite=1, EX_MEM_wr_addr≠0 and EX_MEM_wr_addr==rs_addr.
  - Source 2: MEM_WB_wr_data when MEM_WB_RegWrite=1, MEM_WB_wr_addr≠0 and MEM_WB_wr_addr==rs_addr.
  - Otherwise the ID/EX data is used.
  - Load-use hazards are resolved upstream; this stage never forwards load data from EX/MEM.
- Operand A = forwarded rs. Operand B = ALUSrc ? imm_ext : forwarded rt.
- Destination address = RegDst ? rd_addr : rt_addr.
- Store data = forwarded rt.
- ALU_ctrl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR.
  - 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLTU (unsigned, result 0/1).
  - 1001 SLL B<<shamt, 1010 SRL B>>shamt, 1011 SRA B>>>shamt (arithmetic).
  - 1100 LUI imm_ext[15:0]<<16.
  - 1101 MULTU (result 0), 1110 MFHI (HI), 1111 MFLO (LO).
  - 0101 reserved, result 0.
- ADD and SUB wrap modulo 2^32; no overflow trap.
- Multiplier FSM has two states, IDLE and BUSY:
  - IDLE→BUSY when a MULTU is in EX with EX_stall=0. Operands A and B are latched, the 64-bit accumulator is cleared and the count is set to 0.
  - BUSY performs one shift-add step per cycle. The count runs 0..31.
  - On the edge where count==31, {HI,LO} is loaded with the 64-bit unsigned product and the FSM returns to IDLE.
- EX_stall = (state==BUSY) && ALU_ctrl ∈ {MULTU, MFHI, MFLO}. It is 0 for all other operations, so independent instructions keep flowing during a multiply.
- While EX_stall=1, EX/MEM captures a bubble: all four CU bits 0. Address and data fields are don't-care and are driven 0.
- MULTU itself retires as a bubble-equivalent instruction. Decode supplies RegWrite=0 for it, and the stage does not override this.

## Timing
- On reset, all of the following are 0: EX_MEM outputs, HI, LO, accumulator and count. The FSM goes to IDLE.
- EX_stall is 0 in the cycle after reset, regardless of ALU_ctrl.
- A reset asserted during BUSY aborts the multiply; HI/LO stay 0.
- Ordinary ops have 1-cycle latency: the result appears on EX_MEM outputs after the edge that ends the EX cycle.
- MULTU in EX in cycle t:
  - BUSY in cycles t+1..t+32.
  - HI/LO are written on the edge ending t+32.
  - The earliest non-stalled MFHI/MFLO or next MULTU executes in cycle t+33.
- An MFHI immediately following a MULTU has EX_stall=1 for exactly 32 cycles.
- The EX/MEM register has no hold input; the memory stage never stalls.

## Test plan
- Reset: hold rst for 2 cycles with random inputs → all outputs 0 and EX_stall=0 on the first edge after release.
- ALU sweep, A=0xFFFF_FFF0 and B=0x0000_0020 →
  - ADD=0x0000_0010.
  - SLT=1, SLTU=0.
  - SRA with shamt=4 on B=0x8000_0000 gives 0xF800_0000.
  - LUI with imm 0x1234 gives 0x1234_0000.
- Forwarding: EX_MEM and MEM_WB both target register 5 with values 0xAAAA and 0xBBBB, rs_addr=5 → EX/MEM value 0xAAAA wins. With target register 0, ID/EX data is used.
- Multiply: MULTU 0xFFFF_FFFF×0xFFFF_FFFF then MFHI →
  - EX_stall high for 32 cycles, with bubbles in EX/MEM.
  - MFHI result 0xFFFF_FFFE.
  - MFLO result 0x0000_0001.
- Overlap: MULTU followed by three ADDs → ADDs complete back-to-back with EX_stall=0.
- Reset mid-multiply: rst at BUSY count 10 → IDLE. A following MFLO returns 0 with no stall.
